// File: rtl/inject_engine.sv
// inject_engine: local PE injection stage for a 4-port router.
// Buffers PE flits in a small FIFO. Each cycle it places the head flit into the
// first free link slot (priority N, E, S, W) and registers all four slots.
//
// Ports
//   clk, rst           : clock, synchronous active-high reset
//   pe_valid, pe_flit  : PE offers a 32-bit flit
//   pe_ready           : FIFO can accept a flit this cycle
//   in_N/E/S/W         : post-ejection link flits (bit1 valid, [3:2] port, [6:4] request)
//   outN/E/S/W         : registered flits toward the routing stage
//   starve             : head flit has waited STARVE_MAX cycles without a free slot
module inject_engine #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned STARVE_MAX = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pe_valid,
  input  logic [31:0] pe_flit,
  output logic        pe_ready,
  input  logic [31:0] in_N,
  input  logic [31:0] in_E,
  input  logic [31:0] in_S,
  input  logic [31:0] in_W,
  output logic [31:0] outN,
  output logic [31:0] outE,
  output logic [31:0] outS,
  output logic [31:0] outW,
  output logic        starve
);

  localparam int unsigned FLIT_W = 32;
  localparam int unsigned NPORT  = 4;
  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
  localparam int unsigned SC_W   = 8;

  // FIFO storage and bookkeeping
  logic [FLIT_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [SC_W-1:0]   r_starve_cnt;
  logic [FLIT_W-1:0] r_out [NPORT];
  logic              r_starve;

  logic [FLIT_W-1:0] w_in       [NPORT];
  logic [FLIT_W-1:0] w_out_next [NPORT];
  logic [NPORT-1:0]  w_free;
  logic              w_have;
  logic              w_inject;
  logic [1:0]        w_sel;
  logic              w_push;
  logic [FLIT_W-1:0] w_head;
  logic [FLIT_W-1:0] w_inj_flit;
  logic [CNT_W-1:0]  w_count_next;
  logic [SC_W-1:0]   w_starve_cnt_next;
  logic              w_starve_next;

  // Ready depends on registered occupancy only, so a full FIFO never passes through
  assign pe_ready = !rst && (r_count < CNT_W'(DEPTH));
  assign w_push   = pe_valid && pe_ready;

  // Slot selection, injection merge and next-state computation
  always_comb begin
    w_in[0]           = in_N;
    w_in[1]           = in_E;
    w_in[2]           = in_S;
    w_in[3]           = in_W;
    w_have            = (r_count != '0);
    w_inject          = 1'b0;
    w_sel             = 2'd0;
    w_head            = r_mem[r_rd_ptr];
    w_free            = '0;
    w_starve_cnt_next = r_starve_cnt;

    for (int i = 0; i < NPORT; i++) begin
      w_free[i] = ~w_in[i][1];
    end

    if (w_have) begin
      if (w_free[0]) begin
        w_inject = 1'b1;
        w_sel    = 2'd0;
      end else if (w_free[1]) begin
        w_inject = 1'b1;
        w_sel    = 2'd1;
      end else if (w_free[2]) begin
        w_inject = 1'b1;
        w_sel    = 2'd2;
      end else if (w_free[3]) begin
        w_inject = 1'b1;
        w_sel    = 2'd3;
      end
    end

    // Injected flit: mark valid and stamp the slot code, payload untouched
    w_inj_flit = {w_head[FLIT_W-1:4], w_sel, 1'b1, w_head[0]};

    for (int i = 0; i < NPORT; i++) begin
      w_out_next[i] = (w_inject && (w_sel == 2'(i))) ? w_inj_flit : w_in[i];
    end

    w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_inject);

    if (!w_have || w_inject) begin
      w_starve_cnt_next = '0;
    end else if (r_starve_cnt < SC_W'(STARVE_MAX)) begin
      w_starve_cnt_next = r_starve_cnt + SC_W'(1);
    end

    // starve tracks the counter value being registered this edge
    w_starve_next = (w_starve_cnt_next == SC_W'(STARVE_MAX));
  end

  // Control and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_starve_cnt <= '0;
      r_starve     <= 1'b0;
      for (int i = 0; i < NPORT; i++) begin
        r_out[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_inject) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count      <= w_count_next;
      r_starve_cnt <= w_starve_cnt_next;
      r_starve     <= w_starve_next;
      for (int i = 0; i < NPORT; i++) begin
        r_out[i] <= w_out_next[i];
      end
    end
  end

  // FIFO data array; occupancy is guarded by r_count so no reset needed
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= pe_flit;
    end
  end

  assign outN   = r_out[0];
  assign outE   = r_out[1];
  assign outS   = r_out[2];
  assign outW   = r_out[3];
  assign starve = r_starve;

endmodule

// File: tb/tb_inject_engine.sv
// Self-checking bench for inject_engine: queue-based reference model plus
// directed scenarios with hand-computed literal expectations.
module tb_inject_engine;

  localparam int DEPTH = 4;
  localparam int SMAX  = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        pe_valid;
  logic [31:0] pe_flit;
  logic        pe_ready;
  logic [31:0] in_N, in_E, in_S, in_W;
  logic [31:0] outN, outE, outS, outW;
  logic        starve;

  int nchk = 0;
  int nerr = 0;

  // Reference model state
  logic [31:0] q [$];
  int          sc;
  logic [31:0] eo [4];

  inject_engine #(.DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst), .pe_valid(pe_valid), .pe_flit(pe_flit), .pe_ready(pe_ready),
    .in_N(in_N), .in_E(in_E), .in_S(in_S), .in_W(in_W),
    .outN(outN), .outE(outE), .outS(outS), .outW(outW), .starve(starve)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check ready, advance model, check registered outputs
  task automatic step(input logic r, input logic pv, input logic [31:0] pf,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] c, input logic [31:0] d);
    logic [31:0] ii [4];
    int  sel;
    bit  pushed;
    @(negedge clk);
    rst = r; pe_valid = pv; pe_flit = pf;
    in_N = a; in_E = b; in_S = c; in_W = d;
    ii[0] = a; ii[1] = b; ii[2] = c; ii[3] = d;
    #1;
    chk("pe_ready", 32'(pe_ready), 32'(!r && (q.size() < DEPTH)));
    if (r) begin
      q.delete();
      sc = 0;
      for (int i = 0; i < 4; i++) eo[i] = '0;
    end else begin
      pushed = pv && (q.size() < DEPTH);
      for (int i = 0; i < 4; i++) eo[i] = ii[i];
      sel = -1;
      if (q.size() > 0) begin
        for (int i = 0; i < 4; i++) if (sel < 0 && !ii[i][1]) sel = i;
        if (sel >= 0) begin
          eo[sel]      = q[0];
          eo[sel][1]   = 1'b1;
          eo[sel][3:2] = 2'(sel);
          void'(q.pop_front());
          sc = 0;
        end else if (sc < SMAX) begin
          sc++;
        end
      end else begin
        sc = 0;
      end
      if (pushed) q.push_back(pf);
    end
    @(posedge clk);
    #1;
    chk("outN", outN, eo[0]);
    chk("outE", outE, eo[1]);
    chk("outS", outS, eo[2]);
    chk("outW", outW, eo[3]);
    chk("starve", 32'(starve), 32'(sc == SMAX));
    chk("count", 32'(dut.r_count), 32'(q.size()));
  endtask

  function automatic logic [31:0] rnd_slot();
    logic [31:0] x;
    x    = $urandom;
    x[1] = ($urandom_range(0, 9) < 6);
    return x;
  endfunction

  initial begin
    rst = 1'b1; pe_valid = 1'b0; pe_flit = '0;
    in_N = '0; in_E = '0; in_S = '0; in_W = '0;
    sc = 0;
    for (int i = 0; i < 4; i++) eo[i] = '0;

    // Reset state, then single flit into idle links lands on outN
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 32'hDEAD_BEE0, 0, 0, 0, 0);
    chk("rst_outN", outN, 32'h0);
    chk("rst_starve", 32'(starve), 32'h0);
    step(0, 1, 32'h0000_1042, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("first_outN", outN, 32'h0000_1042);
    chk("first_outE", outE, 32'h0);

    // N and E busy, S free: flit stamped with code 10 on outS
    step(0, 1, 32'h0000_ABC0, 2, 2, 2, 2);
    step(0, 0, 0, 32'h12, 32'h36, 0, 0);
    chk("s_outS", outS, 32'h0000_ABCA);
    chk("s_outN", outN, 32'h12);
    chk("s_outE", outE, 32'h36);
    chk("s_outW", outW, 32'h0);

    // Fill with all slots busy, starve after 15 blocked cycles, release via W
    step(1, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) step(0, 1, 32'h100 * (k + 1), 2, 2, 2, 2);
    chk("full_ready", 32'(pe_ready), 32'h0);
    for (int k = 0; k < 10; k++) step(0, 0, 0, 2, 2, 2, 2);
    chk("starve_14", 32'(starve), 32'h0);
    step(0, 0, 0, 2, 2, 2, 2);
    chk("starve_15", 32'(starve), 32'h1);
    step(0, 0, 0, 2, 2, 2, 2);
    chk("starve_sat", 32'(starve), 32'h1);
    step(0, 0, 0, 2, 2, 2, 0);
    chk("rel_outW", outW, 32'h0000_010E);
    chk("rel_starve", 32'(starve), 32'h0);
    chk("rel_ready", 32'(pe_ready), 32'h1);
    for (int k = 0; k < 4; k++) step(0, 0, 0, 0, 0, 0, 0);

    // Two queued flits drain on outN in push order
    step(0, 1, 32'h5550, 2, 2, 2, 2);
    step(0, 1, 32'h7770, 2, 2, 2, 2);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("drain1_outN", outN, 32'h5552);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("drain2_outN", outN, 32'h7772);
    step(0, 0, 0, 0, 0, 0, 0);

    // Pointer wrap: nine back-to-back push/pop pairs
    for (int k = 0; k < 9; k++) step(0, 1, 32'h1000 * (k + 1), 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);

    // Reset with three flits queued discards them
    for (int k = 0; k < 3; k++) step(0, 1, 32'hF000 + 32'(k) * 32'h10, 2, 2, 2, 2);
    step(1, 0, 0, 2, 2, 2, 2);
    chk("mid_rst_outN", outN, 32'h0);
    chk("mid_rst_starve", 32'(starve), 32'h0);
    chk("mid_rst_count", 32'(dut.r_count), 32'h0);
    for (int k = 0; k < 4; k++) step(0, 0, 0, 0, 0, 0, 0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 149) == 0), ($urandom_range(0, 9) < 7), $urandom,
           rnd_slot(), rnd_slot(), rnd_slot(), rnd_slot());
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
